// File: rtl/gemv_pkg.sv
// Shared definitions for the GEMV datapath: default element width and array
// dimension (mirroring def.vh), the element type and the skew-feeder FSM states.
package gemv_pkg;

    localparam int DEF_DW = 16;  // element width in bits
    localparam int DEF_SZ = 3;   // array dimension = lanes per row

    typedef logic [DEF_DW-1:0] elem_t;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } feed_state_e;

endpackage

// File: rtl/gemv_lane_delay.sv
// Enable-gated shift chain for one lane of the skew feeder. A lane with
// DEPTH=k+1 delays its element by k+1 advances; dout is the last stage.
module gemv_lane_delay #(
    parameter int DW    = 16,
    parameter int DEPTH = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    logic [DW-1:0] stage [DEPTH];

    // Shift one position per advance; the chain freezes when en is low.
    // NOTE: the chain is reset even though it is data storage, because a reset mid-frame must not leak old elements into the next frame's leading zeros.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else if (en) begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/gemv_skew_feeder.sv
// Skew feeder for the GEMV systolic array. Accepts one activation row per
// beat and emits the diagonally skewed wavefront for array.A: lane k is
// delayed k beats and zero-padded before and after its data.
// Optional feature: define GEMV_FEEDER_ROWCNT_EN to add the rows_seen output
// (rows accepted in the current frame, saturating at 16'hFFFF).
module gemv_skew_feeder
    import gemv_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int SZ = DEF_SZ
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] in_row [SZ-1:0],
    input  logic          in_valid,
    input  logic          in_last,
    output logic          in_ready,
    output logic [DW-1:0] out_vec [SZ-1:0],
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_first,
`ifdef GEMV_FEEDER_ROWCNT_EN
    output logic [15:0]   rows_seen,
`endif
    output logic          out_last
);

    // drain_cnt counts 0..SZ-2; keep it at least one bit wide for SZ<=2.
    localparam int CW = (SZ > 2) ? $clog2(SZ - 1) : 1;
    localparam logic [CW-1:0] DRAIN_LAST = CW'((SZ > 1) ? (SZ - 2) : 0);

    feed_state_e   state, state_nxt;
    logic [CW-1:0] drain_cnt, drain_nxt;

    logic slot_free;
    logic accept;
    logic advance;
    logic last_beat;

    assign slot_free = !out_valid || out_ready;
    assign in_ready  = slot_free && (state != DRAIN) && !rst;
    assign accept    = in_valid && in_ready;
    assign advance   = accept || ((state == DRAIN) && slot_free);

    // The beat being produced now closes the frame: final drain advance, or
    // the in_last accept itself when there is only one lane.
    assign last_beat = ((state == DRAIN) && (drain_cnt == DRAIN_LAST))
                     || ((SZ == 1) && accept && in_last);

    // State register and drain counter.
    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values; combinational blocks use blocking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_nxt;
        end
    end

    // Next-state logic: a frame ends with SZ-1 zero-fed drain advances.
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    always_comb begin
        state_nxt = state;
        drain_nxt = drain_cnt;
        case (state)
            IDLE, STREAM: begin
                if (accept) begin
                    if (in_last) begin
                        state_nxt = (SZ > 1) ? DRAIN : IDLE;
                    end else begin
                        state_nxt = STREAM;
                    end
                end
            end
            DRAIN: begin
                if (slot_free) begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state_nxt = IDLE;
                        drain_nxt = '0;
                    end else begin
                        drain_nxt = drain_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                drain_nxt = '0;
            end
        endcase
    end

    // One delay chain per lane; lane k is k+1 deep so row r, lane k lands
    // on beat r+k. Drain advances feed zeros to flush the chains.
    for (genvar k = 0; k < SZ; k++) begin : g_lane
        logic [DW-1:0] lane_src;

        assign lane_src = (state == DRAIN) ? '0 : in_row[k];

        gemv_lane_delay #(
            .DW    (DW),
            .DEPTH (k + 1)
        ) u_lane (
            .clk  (clk),
            .rst  (rst),
            .en   (advance),
            .din  (lane_src),
            .dout (out_vec[k])
        );
    end

    // Output beat flags: set on every advance, held while the beat is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
        end else if (advance) begin
            out_valid <= 1'b1;
            out_first <= (state == IDLE);
            out_last  <= last_beat;
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
        end
    end

`ifdef GEMV_FEEDER_ROWCNT_EN
    // Rows accepted in the current frame; restarts on the frame's first accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rows_seen <= '0;
        end else if (accept) begin
            if (state == IDLE) begin
                rows_seen <= 16'd1;
            end else if (rows_seen != 16'hFFFF) begin
                rows_seen <= rows_seen + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_gemv_skew_feeder.sv
// Directed bench for gemv_skew_feeder (DW=16, SZ=3). Inputs change 1 time
// unit after the rising edge; outputs are sampled there too.
module tb_gemv_skew_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_row [2:0];
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [15:0] out_vec [2:0];
    logic        out_valid;
    logic        out_ready;
    logic        out_first;
    logic        out_last;
`ifdef GEMV_FEEDER_ROWCNT_EN
    logic [15:0] rows_seen;
`endif

    int checks   = 0;
    int failures = 0;

    gemv_skew_feeder #(
        .DW (16),
        .SZ (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_row    (in_row),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_vec   (out_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_first (out_first),
`ifdef GEMV_FEEDER_ROWCNT_EN
        .rows_seen (rows_seen),
`endif
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic l,
                         input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] a2);
        in_valid  = v;
        in_last   = l;
        in_row[0] = a0;
        in_row[1] = a1;
        in_row[2] = a2;
    endtask

    task automatic chk_ready(input string tag, input logic exp);
        #1;
        check({tag, ".in_ready"}, 64'(in_ready), 64'(exp));
    endtask

    task automatic chk_vec(input string tag, input logic [15:0] e2, input logic [15:0] e1,
                           input logic [15:0] e0);
        check({tag, ".vec"}, 64'({out_vec[2], out_vec[1], out_vec[0]}), 64'({e2, e1, e0}));
    endtask

    // Expected wavefront beat: out_vec{2,1,0} plus first/last flags.
    task automatic beat(input string tag, input logic [15:0] e2, input logic [15:0] e1,
                        input logic [15:0] e0, input logic f, input logic l);
        check({tag, ".valid"}, 64'(out_valid), 64'd1);
        chk_vec(tag, e2, e1, e0);
        check({tag, ".first"}, 64'(out_first), 64'(f));
        check({tag, ".last"}, 64'(out_last), 64'(l));
    endtask

    initial begin
        rst       = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, 1'b0, 16'd0, 16'd0, 16'd0);

        // Reset state.
        #2;
        check("rst.valid", 64'(out_valid), 64'd0);
        check("rst.first", 64'(out_first), 64'd0);
        check("rst.last", 64'(out_last), 64'd0);
        chk_vec("rst", 16'd0, 16'd0, 16'd0);
        check("rst.in_ready", 64'(in_ready), 64'd0);
        tick();
        tick();
        rst = 1'b0;
        chk_ready("rst.release", 1'b1);

        // 1: three rows back-to-back.
        drive(1'b1, 1'b0, 16'd1, 16'd2, 16'd3);
        chk_ready("t1.r0", 1'b1);
        tick();
        beat("t1.b0", 16'd0, 16'd0, 16'd1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 16'd4, 16'd5, 16'd6);
        tick();
        beat("t1.b1", 16'd0, 16'd2, 16'd4, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 16'd7, 16'd8, 16'd9);
        tick();
        beat("t1.b2", 16'd3, 16'd5, 16'd7, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 16'd0, 16'd0, 16'd0);
        chk_ready("t1.drain0", 1'b0);
        tick();
        beat("t1.b3", 16'd6, 16'd8, 16'd0, 1'b0, 1'b0);
        chk_ready("t1.drain1", 1'b0);
        tick();
        beat("t1.b4", 16'd9, 16'd0, 16'd0, 1'b0, 1'b1);
        chk_ready("t1.idle", 1'b1);
        tick();
        check("t1.end.valid", 64'(out_valid), 64'd0);

        // 2: two-cycle in_valid gap after row 1.
        drive(1'b1, 1'b0, 16'd1, 16'd2, 16'd3);
        tick();
        beat("t2.b0", 16'd0, 16'd0, 16'd1, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 16'd0, 16'd0, 16'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("t2.gap.valid", 64'(out_valid), 64'd0);
            chk_vec("t2.gap", 16'd0, 16'd0, 16'd1);
        end
        drive(1'b1, 1'b0, 16'd4, 16'd5, 16'd6);
        tick();
        beat("t2.b1", 16'd0, 16'd2, 16'd4, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 16'd7, 16'd8, 16'd9);
        tick();
        beat("t2.b2", 16'd3, 16'd5, 16'd7, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 16'd0, 16'd0, 16'd0);
        tick();
        beat("t2.b3", 16'd6, 16'd8, 16'd0, 1'b0, 1'b0);
        tick();
        beat("t2.b4", 16'd9, 16'd0, 16'd0, 1'b0, 1'b1);
        tick();
        check("t2.end.valid", 64'(out_valid), 64'd0);

        // 3: out_ready low for 3 cycles while beat {3,5,7} is presented.
        drive(1'b1, 1'b0, 16'd1, 16'd2, 16'd3);
        tick();
        beat("t3.b0", 16'd0, 16'd0, 16'd1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 16'd4, 16'd5, 16'd6);
        tick();
        beat("t3.b1", 16'd0, 16'd2, 16'd4, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 16'd7, 16'd8, 16'd9);
        tick();
        beat("t3.b2", 16'd3, 16'd5, 16'd7, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 16'd0, 16'd0, 16'd0);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk_ready("t3.stall", 1'b0);
            tick();
            beat("t3.hold", 16'd3, 16'd5, 16'd7, 1'b0, 1'b0);
        end
        out_ready = 1'b1;
        tick();
        beat("t3.b3", 16'd6, 16'd8, 16'd0, 1'b0, 1'b0);
        tick();
        beat("t3.b4", 16'd9, 16'd0, 16'd0, 1'b0, 1'b1);
        tick();
        check("t3.end.valid", 64'(out_valid), 64'd0);

        // 4: single-row frame, then another immediately after DRAIN exits.
        drive(1'b1, 1'b1, 16'd5, 16'd6, 16'd7);
        chk_ready("t4.r0", 1'b1);
        tick();
        beat("t4.b0", 16'd0, 16'd0, 16'd5, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 16'd0, 16'd0, 16'd0);
        chk_ready("t4.drain0", 1'b0);
        tick();
        beat("t4.b1", 16'd0, 16'd6, 16'd0, 1'b0, 1'b0);
        chk_ready("t4.drain1", 1'b0);
        tick();
        beat("t4.b2", 16'd7, 16'd0, 16'd0, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 16'd1, 16'd1, 16'd1);
        chk_ready("t4.next", 1'b1);
        tick();
        beat("t4.c0", 16'd0, 16'd0, 16'd1, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 16'd0, 16'd0, 16'd0);
        tick();
        beat("t4.c1", 16'd0, 16'd1, 16'd0, 1'b0, 1'b0);
        tick();
        beat("t4.c2", 16'd1, 16'd0, 16'd0, 1'b0, 1'b1);
        tick();
        check("t4.end.valid", 64'(out_valid), 64'd0);

        // 5: asynchronous reset in the middle of DRAIN.
        drive(1'b1, 1'b0, 16'd1, 16'd2, 16'd3);
        tick();
        beat("t5.b0", 16'd0, 16'd0, 16'd1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 16'd4, 16'd5, 16'd6);
        tick();
        beat("t5.b1", 16'd0, 16'd2, 16'd4, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 16'd0, 16'd0, 16'd0);
        #2;
        rst = 1'b1;
        #1;
        check("t5.rst.valid", 64'(out_valid), 64'd0);
        chk_vec("t5.rst", 16'd0, 16'd0, 16'd0);
        check("t5.rst.in_ready", 64'(in_ready), 64'd0);
        tick();
        rst = 1'b0;
        chk_ready("t5.release", 1'b1);
        drive(1'b1, 1'b1, 16'd7, 16'd8, 16'd9);
        tick();
        beat("t5.c0", 16'd0, 16'd0, 16'd7, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 16'd0, 16'd0, 16'd0);
        tick();
        beat("t5.c1", 16'd0, 16'd8, 16'd0, 1'b0, 1'b0);
        tick();
        beat("t5.c2", 16'd9, 16'd0, 16'd0, 1'b0, 1'b1);
        tick();
        check("t5.end.valid", 64'(out_valid), 64'd0);

`ifdef GEMV_FEEDER_ROWCNT_EN
        // 6: rows_seen over a 4-row frame and into the next frame.
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, (i == 4), 16'(i), 16'(i), 16'(i));
            tick();
            check("t6.count", 64'(rows_seen), 64'(i));
        end
        drive(1'b0, 1'b0, 16'd0, 16'd0, 16'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6.held", 64'(rows_seen), 64'd4);
        end
        drive(1'b1, 1'b1, 16'd2, 16'd2, 16'd2);
        tick();
        check("t6.restart", 64'(rows_seen), 64'd1);
        drive(1'b0, 1'b0, 16'd0, 16'd0, 16'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
